// File: rtl/i2s_mic_pkg.sv
// Shared constants for the I2S microphone receiver.
// Default geometry and channel encoding used by the top and the bench.
package i2s_mic_pkg;

    localparam int SLOT_W_DEF     = 32;
    localparam int SAMPLE_W_DEF   = 24;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic {
        SLOT_LEFT  = CH_LEFT,
        SLOT_RIGHT = CH_RIGHT
    } slot_e;

    function automatic logic chan_on(input logic [1:0] en, input logic ch);
        return en[ch];
    endfunction

endpackage

// File: rtl/i2s_mic_rx_fifo.sv
// Small synchronous FIFO holding tagged samples.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a write when the head leaves this cycle
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata = mem[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: generates sck/ws from mclk, captures
// MSB-first samples per slot and queues them with a channel tag.
module i2s_mic_rx
    import i2s_mic_pkg::*;
#(
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          chan_en,
    output logic                sck,
    output logic                ws,
    input  logic                sd,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ch,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overflow,
    input  logic                clr_ovf
);

    localparam int CW = $clog2(SLOT_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(SLOT_W - 1);
    localparam logic [CW-1:0] PUSH_BIT = CW'(SAMPLE_W);

    logic                sck_q, sck_d;
    logic                ws_q, ws_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] sr_q, sr_d;
    logic                ovf_q, ovf_d;
    logic [SAMPLE_W-1:0] sr_nx;
    logic                fall;
    logic                in_word;
    logic                push;
    logic                pop;
    logic                drop;
    logic                full;
    logic                empty;
    logic [SAMPLE_W:0]   wdata;
    logic [SAMPLE_W:0]   rdata;

    // sd is launched off our own sck, so it is sampled directly
    assign fall    = enable & sck_q;
    assign sr_nx   = SAMPLE_W'({sr_q, sd});
    assign in_word = (cnt_q != '0) && (cnt_q <= PUSH_BIT);

    assign push  = fall && (cnt_q == PUSH_BIT) && chan_on(chan_en, ws_q);
    assign wdata = {ws_q, sr_nx};
    assign pop   = ~empty & sample_ready;
    assign drop  = push & full & ~pop;

    always_comb begin
        sck_d = sck_q;
        ws_d  = ws_q;
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (!enable) begin
            sck_d = 1'b0;
            ws_d  = SLOT_LEFT;
            cnt_d = '0;
            sr_d  = '0;
        end else begin
            sck_d = ~sck_q;
            if (sck_q) begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    ws_d  = ~ws_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (in_word) sr_d = sr_nx;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            sck_q <= 1'b0;
            ws_q  <= 1'b0;
            cnt_q <= '0;
            sr_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            sck_q <= sck_d;
            ws_q  <= ws_d;
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            ovf_q <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mclk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign sck          = sck_q;
    assign ws           = ws_q;
    assign overflow     = ovf_q;
    assign sample_valid = ~empty;
    assign sample_ch    = ~empty & rdata[SAMPLE_W];
    assign sample_data  = empty ? '0 : rdata[SAMPLE_W-1:0];

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx with a behavioural I2S microphone.
// Inputs change and outputs are sampled on the falling edge of mclk.
module tb_i2s_mic_rx;
    import i2s_mic_pkg::*;

    localparam int SLOT_W   = 32;
    localparam int SAMPLE_W = 24;
    localparam int DEPTH    = 4;

    logic                mclk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [1:0]          chan_en = 2'b11;
    logic                sd = 1'b0;
    logic                sample_ready = 1'b0;
    logic                clr_ovf = 1'b0;
    logic                sck;
    logic                ws;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_ch;
    logic                sample_valid;
    logic                overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [SAMPLE_W-1:0] mic_l = '0;
    logic [SAMPLE_W-1:0] mic_r = '0;
    int   m_idx = 0;
    logic m_ch = 1'b0;
    logic m_psck = 1'b0;
    logic m_pws = 1'b0;

    i2s_mic_rx #(
        .SLOT_W     (SLOT_W),
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .mclk         (mclk),
        .reset        (reset),
        .enable       (enable),
        .chan_en      (chan_en),
        .sck          (sck),
        .ws           (ws),
        .sd           (sd),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf)
    );

    always #5 mclk = ~mclk;

    // Delay bit and trailing bits are driven high: the receiver must ignore them
    function automatic logic mic_bit(input logic ch, input int idx);
        logic [SAMPLE_W-1:0] w;
        w = ch ? mic_r : mic_l;
        if (idx >= 1 && idx <= SAMPLE_W) return w[SAMPLE_W-idx];
        return 1'b1;
    endfunction

    // Microphone: a ws change restarts the slot, each sck fall advances a bit
    always @(negedge mclk) begin
        if (reset || !enable) begin
            m_idx  = 0;
            m_ch   = 1'b0;
            m_psck = 1'b0;
            m_pws  = 1'b0;
        end else begin
            if (m_psck && !sck) begin
                if (ws != m_pws) begin
                    m_idx = 0;
                    m_ch  = ws;
                end else begin
                    m_idx++;
                end
            end
            m_psck = sck;
            m_pws  = ws;
        end
        sd = mic_bit(m_ch, m_idx);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        sample_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) @(negedge mclk);
        reset = 1'b0;
        @(negedge mclk);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge mclk);
            if (sample_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pop_one();
        sample_ready = 1'b1;
        @(negedge mclk);
        sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        sample_ready = 1'b1;
        clr_ovf = 1'b1;
        repeat (3) @(negedge mclk);
        tests_run++;
        if (sck !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sck: got %b want 0", sck);
        end
        tests_run++;
        if (ws !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ws: got %b want 0", ws);
        end
        tests_run++;
        if (sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b want 0", sample_valid);
        end
        tests_run++;
        if (sample_ch !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ch: got %b want 0", sample_ch);
        end
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf: got %b want 0", overflow);
        end
        tests_run++;
        if (sample_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0", sample_data);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int n;
        int tg;
        int t0;
        int t1;
        logic p;
        do_reset();
        mic_l = 24'hA5A5A5;
        mic_r = 24'h123456;
        chan_en = 2'b11;
        enable = 1'b1;
        wait_valid(200, n);
        tests_run++;
        if (n !== 50) begin
            tests_failed++;
            $display("FAIL basic_left_latency: got %0d want 50", n);
        end
        tests_run++;
        if (sample_data !== 24'hA5A5A5) begin
            tests_failed++;
            $display("FAIL basic_left_data: got %h want a5a5a5", sample_data);
        end
        tests_run++;
        if (sample_ch !== CH_LEFT) begin
            tests_failed++;
            $display("FAIL basic_left_ch: got %b want 0", sample_ch);
        end
        pop_one();
        wait_valid(200, n);
        tests_run++;
        if (n !== 63) begin
            tests_failed++;
            $display("FAIL basic_right_latency: got %0d want 63", n);
        end
        tests_run++;
        if (sample_data !== 24'h123456) begin
            tests_failed++;
            $display("FAIL basic_right_data: got %h want 123456", sample_data);
        end
        tests_run++;
        if (sample_ch !== CH_RIGHT) begin
            tests_failed++;
            $display("FAIL basic_right_ch: got %b want 1", sample_ch);
        end
        pop_one();
        tg = 0;
        p = sck;
        repeat (8) begin
            @(negedge mclk);
            if (sck !== p) tg++;
            p = sck;
        end
        tests_run++;
        if (tg !== 8) begin
            tests_failed++;
            $display("FAIL basic_sck_toggle: got %0d want 8", tg);
        end
        sample_ready = 1'b1;
        t0 = -1;
        t1 = -1;
        p = ws;
        for (int i = 0; i < 400; i++) begin
            @(negedge mclk);
            if (ws === 1'b1 && p === 1'b0) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
            end
            p = ws;
        end
        sample_ready = 1'b0;
        tests_run++;
        if (t0 < 0 || t1 - t0 !== 128) begin
            tests_failed++;
            $display("FAIL basic_ws_period: got %0d want 128", t1 - t0);
        end
    endtask

    task automatic test_left_only();
        int nl;
        int nr;
        int bad;
        do_reset();
        mic_l = 24'h800001;
        mic_r = 24'h7FFFFE;
        chan_en = 2'b01;
        sample_ready = 1'b1;
        enable = 1'b1;
        nl = 0;
        nr = 0;
        bad = 0;
        repeat (384) begin
            @(negedge mclk);
            if (sample_valid && sample_ready) begin
                if (sample_ch) begin
                    nr++;
                end else begin
                    nl++;
                    if (sample_data !== mic_l) bad++;
                end
            end
        end
        tests_run++;
        if (nl !== 3) begin
            tests_failed++;
            $display("FAIL left_only_count: got %0d want 3", nl);
        end
        tests_run++;
        if (nr !== 0) begin
            tests_failed++;
            $display("FAIL left_only_right: got %0d want 0", nr);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL left_only_data: got %0d bad want 0", bad);
        end
    endtask

    task automatic test_overflow();
        logic                exp_ch;
        logic [SAMPLE_W-1:0] exp_d;
        do_reset();
        mic_l = 24'h111111;
        mic_r = 24'h222222;
        chan_en = 2'b11;
        enable = 1'b1;
        repeat (300) @(negedge mclk);
        tests_run++;
        if (overflow !== 1'b0 || sample_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_full_no_drop: got ovf=%b v=%b want 0 1",
                     overflow, sample_valid);
        end
        repeat (5) @(negedge mclk);
        clr_ovf = 1'b1;
        @(negedge mclk);
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: got %b want 1", overflow);
        end
        repeat (4) @(negedge mclk);
        enable = 1'b0;
        repeat (2) @(negedge mclk);
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 1);
            exp_d = exp_ch ? mic_r : mic_l;
            tests_run++;
            if (sample_valid !== 1'b1 || sample_ch !== exp_ch ||
                sample_data !== exp_d) begin
                tests_failed++;
                $display("FAIL ovf_drain%0d: got v=%b ch=%b d=%h want 1 %b %h",
                         i, sample_valid, sample_ch, sample_data, exp_ch, exp_d);
            end
            pop_one();
        end
        tests_run++;
        if (sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_fifth_dropped: got v=%b want 0", sample_valid);
        end
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        clr_ovf = 1'b1;
        @(negedge mclk);
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic exp_ch;
        do_reset();
        mic_l = 24'h0000FF;
        mic_r = 24'hFF0000;
        chan_en = 2'b11;
        enable = 1'b1;
        repeat (305) @(negedge mclk);
        tests_run++;
        if (sample_valid !== 1'b1 || sample_ch !== CH_LEFT) begin
            tests_failed++;
            $display("FAIL full_pop_head: got v=%b ch=%b want 1 0",
                     sample_valid, sample_ch);
        end
        sample_ready = 1'b1;
        @(negedge mclk);
        sample_ready = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pop_ovf: got %b want 0", overflow);
        end
        enable = 1'b0;
        repeat (2) @(negedge mclk);
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 0);
            tests_run++;
            if (sample_valid !== 1'b1 || sample_ch !== exp_ch ||
                sample_data !== (exp_ch ? mic_r : mic_l)) begin
                tests_failed++;
                $display("FAIL full_pop_drain%0d: got v=%b ch=%b d=%h want ch %b",
                         i, sample_valid, sample_ch, sample_data, exp_ch);
            end
            pop_one();
        end
        tests_run++;
        if (sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pop_empty: got v=%b want 0", sample_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        mic_l = 24'h5A5A5A;
        mic_r = 24'h0F0F0F;
        chan_en = 2'b11;
        enable = 1'b1;
        repeat (85) @(negedge mclk);
        tests_run++;
        if (sample_valid !== 1'b1 || ws !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got v=%b ws=%b want 1 1",
                     sample_valid, ws);
        end
        reset = 1'b1;
        @(negedge mclk);
        tests_run++;
        if ({sck, ws, sample_valid, sample_ch, overflow, sample_data} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got sck=%b ws=%b v=%b ch=%b o=%b d=%h want 0",
                     sck, ws, sample_valid, sample_ch, overflow, sample_data);
        end
        @(negedge mclk);
        reset = 1'b0;
        wait_valid(200, n);
        tests_run++;
        if (n !== 50) begin
            tests_failed++;
            $display("FAIL rst_mid_latency: got %0d want 50", n);
        end
        tests_run++;
        if (sample_data !== 24'h5A5A5A || sample_ch !== CH_LEFT) begin
            tests_failed++;
            $display("FAIL rst_mid_sample: got %h ch %b want 5a5a5a ch 0",
                     sample_data, sample_ch);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        do_reset();
        mic_l = 24'h3C3C3C;
        chan_en = 2'b01;
        enable = 1'b1;
        repeat (26) @(negedge mclk);
        enable = 1'b0;
        repeat (10) @(negedge mclk);
        tests_run++;
        if (sck !== 1'b0 || ws !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_drop_idle: got sck=%b ws=%b want 0 0", sck, ws);
        end
        tests_run++;
        if (sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_drop_partial: got v=%b want 0", sample_valid);
        end
        mic_l = 24'hC3C3C3;
        enable = 1'b1;
        wait_valid(200, n);
        tests_run++;
        if (n !== 50) begin
            tests_failed++;
            $display("FAIL en_drop_latency: got %0d want 50", n);
        end
        tests_run++;
        if (sample_data !== 24'hC3C3C3 || sample_ch !== CH_LEFT) begin
            tests_failed++;
            $display("FAIL en_drop_sample: got %h ch %b want c3c3c3 ch 0",
                     sample_data, sample_ch);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_left_only();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
